// File: rtl/exec_sequencer_if.sv
// Instruction handshake between a requester and the exec_sequencer.
// The requester drives valid/instr; the sequencer answers with ready.
interface exec_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input  instr_ready);
    modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/exec_sequencer.sv
// Five-state instruction sequencer: fetch into IR, decode, optional stalled
// execute, single-cycle write-back strobes, terminal HALT.
module exec_sequencer (
    input  logic                   clk,
    input  logic                   reset,
    exec_sequencer_if.slave        bus,
    input  logic                   stall,
    output logic [2:0]             sel_a,
    output logic [2:0]             sel_b,
    output logic [2:0]             sel_d,
    output logic [2:0]             alu_op,
    output logic                   reg_write,
    output logic                   flag_write,
    output logic                   halted,
    output logic                   illegal,
    output logic [7:0]             instr_count
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  opcode;

    assign opcode = ir[15:12];

    // NOTE: all state and outputs use non-blocking assignments in one
    // always_ff, so every output is a flop and no latch can be inferred.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the reset branch clears every register, IR included, so a
            // half-finished instruction leaves no trace after reset.
            state           <= IDLE;
            ir              <= '0;
            sel_a           <= '0;
            sel_b           <= '0;
            sel_d           <= '0;
            alu_op          <= '0;
            reg_write       <= 1'b0;
            flag_write      <= 1'b0;
            halted          <= 1'b0;
            illegal         <= 1'b0;
            instr_count     <= '0;
            bus.instr_ready <= 1'b0;
        end else begin
            reg_write  <= 1'b0;
            flag_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        // Selects load straight from the bus so they match IR in DECODE.
                        ir              <= bus.instr;
                        sel_d           <= bus.instr[11:9];
                        sel_a           <= bus.instr[8:6];
                        sel_b           <= bus.instr[5:3];
                        alu_op          <= bus.instr[2:0];
                        bus.instr_ready <= 1'b0;
                        state           <= DECODE;
                    end else begin
                        bus.instr_ready <= 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_NOP:         state <= WB;
                        OP_ALU, OP_CMP: state <= EXEC;
                        OP_HALT: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            illegal <= 1'b1;
                            state   <= WB;
                        end
                    endcase
                end
                EXEC: begin
                    if (!stall) begin
                        state      <= WB;
                        reg_write  <= (opcode == OP_ALU);
                        flag_write <= (opcode == OP_ALU) || (opcode == OP_CMP);
                    end
                end
                WB: begin
                    instr_count     <= instr_count + 8'd1;
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
